// File: rtl/atm_keypad_initiator.sv
// atm_keypad_initiator
//
// Customer-side front end of the ATM. Key strobes from the keypad scanner are
// collected into complete requests (login, balance, withdraw, withdraw+show,
// transfer). Each request is offered to the controller over a valid/ready
// handshake, and then the block waits for a response or a timeout.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   keyValid/keyCode  one-cycle key strobe; 0-9 digit, A ENTER, B CLEAR,
//                     C CANCEL, D-F ignored
//   reqValid/reqReady request handshake towards the controller
//   accNumber, pin, menuOption, amount, destinationAcc
//                     request fields, stable while reqValid is high
//   respValid/respError/respBalance
//                     one-cycle response strobe from the controller
//   exit              one-cycle session-end pulse
//   dispBalance       last good balance, dispValid pulses when it updates
//   entryError        one-cycle pulse on a rejected key, failed login,
//                     error response or timeout
//   busy              high while a request is outstanding (REQ/WAIT_RESP)
module atm_keypad_initiator #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        keyValid,
   input  logic [3:0]  keyCode,
   output logic        reqValid,
   input  logic        reqReady,
   output logic [11:0] accNumber,
   output logic [3:0]  pin,
   output logic [2:0]  menuOption,
   output logic [10:0] amount,
   output logic [11:0] destinationAcc,
   input  logic        respValid,
   input  logic        respError,
   input  logic [10:0] respBalance,
   output logic        exit,
   output logic [10:0] dispBalance,
   output logic        dispValid,
   output logic        entryError,
   output logic        busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_ACC,
      ST_PIN,
      ST_OPT,
      ST_AMT,
      ST_DST,
      ST_REQ,
      ST_WAIT_RESP
   } state_t;

   state_t        state, state_n;
   logic [11:0]   acc_n, dest_n;
   logic [3:0]    pin_n, opt_q, opt_n;
   logic [2:0]    menu_n;
   logic [10:0]   amount_n, disp_n;
   logic [2:0]    acc_cnt, acc_cnt_n, pin_cnt, pin_cnt_n, opt_cnt, opt_cnt_n;
   logic [2:0]    amt_cnt, amt_cnt_n, dst_cnt, dst_cnt_n;
   logic          cancel_pending, cancel_n;
   logic [TW-1:0] timer, timer_n;
   logic          exit_n, disp_valid_n, entry_error_n;
   logic          clear_all, clear_txn, resp_fail;
   logic          key_digit, key_enter, key_clear, key_cancel;
   logic [15:0]   acc_cand, amt_cand, dst_cand;

   // Key decode; codes D-F match none of these and simply fall through.
   assign key_digit  = keyValid && (keyCode <= 4'd9);
   assign key_enter  = keyValid && (keyCode == 4'hA);
   assign key_clear  = keyValid && (keyCode == 4'hB);
   assign key_cancel = keyValid && (keyCode == 4'hC);

   // Candidate values for a decimal digit appended to each numeric field,
   // computed wide enough that the range check can never wrap.
   assign acc_cand = 16'(accNumber) * 16'd10 + 16'(keyCode);
   assign amt_cand = 16'(amount) * 16'd10 + 16'(keyCode);
   assign dst_cand = 16'(destinationAcc) * 16'd10 + 16'(keyCode);

   // The request strobe and busy come straight from the state register so
   // that an asynchronous reset drops them immediately.
   assign reqValid = (state == ST_REQ);
   assign busy     = (state == ST_REQ) || (state == ST_WAIT_RESP);

   // Digit counters only need to tell "empty" from "not empty", so they
   // saturate instead of wrapping back to zero.
   function automatic logic [2:0] bump(input logic [2:0] c);
      return (c == 3'd7) ? c : c + 3'd1;
   endfunction

   // Next-state and datapath logic. Every key is resolved in the state it
   // arrives in. A cancel that arrives while a request is outstanding is
   // remembered in cancel_pending and acted on once the request resolves:
   // if it was already pending at resolution the exit goes out right away,
   // if it arrives together with the resolution it is handled one cycle
   // later from the idle state it lands in. The clear_* flags are applied
   // last so that any branch can request a bulk clear.
   always_comb begin
      state_n       = state;
      acc_n         = accNumber;
      pin_n         = pin;
      opt_n         = opt_q;
      menu_n        = menuOption;
      amount_n      = amount;
      dest_n        = destinationAcc;
      acc_cnt_n     = acc_cnt;
      pin_cnt_n     = pin_cnt;
      opt_cnt_n     = opt_cnt;
      amt_cnt_n     = amt_cnt;
      dst_cnt_n     = dst_cnt;
      disp_n        = dispBalance;
      cancel_n      = cancel_pending;
      timer_n       = timer;
      exit_n        = 1'b0;
      disp_valid_n  = 1'b0;
      entry_error_n = 1'b0;
      clear_all     = 1'b0;
      clear_txn     = 1'b0;
      resp_fail     = 1'b0;

      if (!busy && cancel_pending) begin
         exit_n    = 1'b1;
         clear_all = 1'b1;
         cancel_n  = 1'b0;
         state_n   = ST_ACC;
      end else if (!busy && key_cancel) begin
         exit_n    = 1'b1;
         clear_all = 1'b1;
         disp_n    = '0;
         state_n   = ST_ACC;
      end else begin
         case (state)
            ST_ACC: begin
               if (key_digit) begin
                  if (acc_cand > 16'd4095) entry_error_n = 1'b1;
                  else begin
                     acc_n     = acc_cand[11:0];
                     acc_cnt_n = bump(acc_cnt);
                  end
               end else if (key_enter) begin
                  if (acc_cnt == 3'd0) entry_error_n = 1'b1;
                  else                 state_n = ST_PIN;
               end else if (key_clear) begin
                  acc_n     = '0;
                  acc_cnt_n = '0;
               end
            end
            ST_PIN: begin
               if (key_digit) begin
                  pin_n     = keyCode;
                  pin_cnt_n = bump(pin_cnt);
               end else if (key_enter) begin
                  if (pin_cnt == 3'd0) entry_error_n = 1'b1;
                  else begin
                     menu_n  = 3'd0;
                     state_n = ST_REQ;
                  end
               end else if (key_clear) begin
                  pin_n     = '0;
                  pin_cnt_n = '0;
               end
            end
            ST_OPT: begin
               if (key_digit) begin
                  opt_n     = keyCode;
                  opt_cnt_n = bump(opt_cnt);
               end else if (key_enter) begin
                  if (opt_cnt == 3'd0) entry_error_n = 1'b1;
                  else if (opt_q == 4'd3) begin
                     menu_n  = 3'd3;
                     state_n = ST_REQ;
                  end else if ((opt_q >= 4'd4) && (opt_q <= 4'd6)) begin
                     menu_n  = opt_q[2:0];
                     state_n = ST_AMT;
                  end else entry_error_n = 1'b1;
               end else if (key_clear) begin
                  opt_n     = '0;
                  opt_cnt_n = '0;
               end
            end
            ST_AMT: begin
               if (key_digit) begin
                  if (amt_cand > 16'd2047) entry_error_n = 1'b1;
                  else begin
                     amount_n  = amt_cand[10:0];
                     amt_cnt_n = bump(amt_cnt);
                  end
               end else if (key_enter) begin
                  if (amt_cnt == 3'd0)          entry_error_n = 1'b1;
                  else if (menuOption == 3'd6) state_n = ST_DST;
                  else                         state_n = ST_REQ;
               end else if (key_clear) begin
                  amount_n  = '0;
                  amt_cnt_n = '0;
               end
            end
            ST_DST: begin
               if (key_digit) begin
                  if (dst_cand > 16'd4095) entry_error_n = 1'b1;
                  else begin
                     dest_n    = dst_cand[11:0];
                     dst_cnt_n = bump(dst_cnt);
                  end
               end else if (key_enter) begin
                  if (dst_cnt == 3'd0) entry_error_n = 1'b1;
                  else                 state_n = ST_REQ;
               end else if (key_clear) begin
                  dest_n    = '0;
                  dst_cnt_n = '0;
               end
            end
            ST_REQ: begin
               if (key_cancel) cancel_n = 1'b1;
               if (reqReady) begin
                  state_n = ST_WAIT_RESP;
                  timer_n = '0;
               end
            end
            ST_WAIT_RESP: begin
               if (respValid || (timer == T_LAST)) begin
                  resp_fail = !respValid || respError;
                  if (menuOption == 3'd0) begin
                     if (resp_fail) begin
                        entry_error_n = 1'b1;
                        clear_all     = 1'b1;
                        state_n       = ST_ACC;
                     end else state_n = ST_OPT;
                  end else begin
                     state_n = ST_OPT;
                     if (resp_fail) entry_error_n = 1'b1;
                     else begin
                        disp_n       = respBalance;
                        disp_valid_n = 1'b1;
                        clear_txn    = 1'b1;
                     end
                  end
                  if (cancel_pending) begin
                     exit_n    = 1'b1;
                     clear_all = 1'b1;
                     cancel_n  = 1'b0;
                     state_n   = ST_ACC;
                  end else if (key_cancel) cancel_n = 1'b1;
               end else begin
                  timer_n = timer + TW'(1);
                  if (key_cancel) cancel_n = 1'b1;
               end
            end
            default: state_n = ST_ACC;
         endcase
      end

      if (clear_txn || clear_all) begin
         amount_n  = '0;
         amt_cnt_n = '0;
         dest_n    = '0;
         dst_cnt_n = '0;
      end
      if (clear_all) begin
         acc_n     = '0;
         acc_cnt_n = '0;
         pin_n     = '0;
         pin_cnt_n = '0;
         opt_n     = '0;
         opt_cnt_n = '0;
         menu_n    = '0;
      end
   end

   // State, field and pulse registers. Everything returns to zero / ACC on
   // reset, which also silences any request that was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_ACC;
         accNumber      <= '0;
         pin            <= '0;
         opt_q          <= '0;
         menuOption     <= '0;
         amount         <= '0;
         destinationAcc <= '0;
         acc_cnt        <= '0;
         pin_cnt        <= '0;
         opt_cnt        <= '0;
         amt_cnt        <= '0;
         dst_cnt        <= '0;
         dispBalance    <= '0;
         cancel_pending <= 1'b0;
         timer          <= '0;
         exit           <= 1'b0;
         dispValid      <= 1'b0;
         entryError     <= 1'b0;
      end else begin
         state          <= state_n;
         accNumber      <= acc_n;
         pin            <= pin_n;
         opt_q          <= opt_n;
         menuOption     <= menu_n;
         amount         <= amount_n;
         destinationAcc <= dest_n;
         acc_cnt        <= acc_cnt_n;
         pin_cnt        <= pin_cnt_n;
         opt_cnt        <= opt_cnt_n;
         amt_cnt        <= amt_cnt_n;
         dst_cnt        <= dst_cnt_n;
         dispBalance    <= disp_n;
         cancel_pending <= cancel_n;
         timer          <= timer_n;
         exit           <= exit_n;
         dispValid      <= disp_valid_n;
         entryError     <= entry_error_n;
      end
   end

endmodule

// File: tb/tb_atm_keypad_initiator.sv
// Testbench for atm_keypad_initiator: directed scenarios with literal
// expectations, then randomized key/handshake/response traffic, all
// continuously compared against a behavioural model of the keypad session.
module tb_atm_keypad_initiator;

   localparam int TIMEOUT_CYCLES = 8;
   localparam logic [3:0] K_ENT = 4'hA;
   localparam logic [3:0] K_CLR = 4'hB;
   localparam logic [3:0] K_CAN = 4'hC;

   localparam int P_ACC  = 0;
   localparam int P_PIN  = 1;
   localparam int P_OPT  = 2;
   localparam int P_AMT  = 3;
   localparam int P_DST  = 4;
   localparam int P_REQ  = 5;
   localparam int P_WAIT = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        keyValid;
   logic [3:0]  keyCode;
   logic        reqValid;
   logic        reqReady;
   logic [11:0] accNumber;
   logic [3:0]  pin;
   logic [2:0]  menuOption;
   logic [10:0] amount;
   logic [11:0] destinationAcc;
   logic        respValid;
   logic        respError;
   logic [10:0] respBalance;
   logic        exit;
   logic [10:0] dispBalance;
   logic        dispValid;
   logic        entryError;
   logic        busy;

   int   vectors     = 0;
   int   miscompares = 0;
   logic readyDefault;

   always #5 clk = ~clk;

   atm_keypad_initiator #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .keyValid       (keyValid),
      .keyCode        (keyCode),
      .reqValid       (reqValid),
      .reqReady       (reqReady),
      .accNumber      (accNumber),
      .pin            (pin),
      .menuOption     (menuOption),
      .amount         (amount),
      .destinationAcc (destinationAcc),
      .respValid      (respValid),
      .respError      (respError),
      .respBalance    (respBalance),
      .exit           (exit),
      .dispBalance    (dispBalance),
      .dispValid      (dispValid),
      .entryError     (entryError),
      .busy           (busy)
   );

   // Session model: five editable fields held in arrays (0 account, 1 PIN,
   // 2 pending option, 3 amount, 4 destination), "cur" says which one keys go
   // to, or that a request is being offered / awaiting its answer.
   int fld[5];
   int cnt[5];
   int cur, menu, disp, waited;
   bit pend, xExit, xDv, xErr;

   task automatic clearAll();
      for (int i = 0; i < 5; i++) begin
         fld[i] = 0;
         cnt[i] = 0;
      end
      menu = 0;
   endtask

   task automatic modelReset();
      clearAll();
      cur = P_ACC; disp = 0; waited = 0; pend = 0;
      xExit = 0; xDv = 0; xErr = 0;
   endtask

   task automatic modelStep();
      bit kv;
      int kc, lim, v;
      bit bad;
      kv = keyValid;
      kc = int'(keyCode);
      xExit = 0; xDv = 0; xErr = 0;
      if (cur <= P_DST) begin
         if (pend) begin
            xExit = 1; clearAll(); pend = 0; cur = P_ACC;
         end else if (kv && kc == 12) begin
            xExit = 1; clearAll(); disp = 0; cur = P_ACC;
         end else if (kv && kc <= 9) begin
            if (cur == P_PIN || cur == P_OPT) begin
               fld[cur] = kc; cnt[cur]++;
            end else begin
               lim = (cur == P_AMT) ? 2047 : 4095;
               v = fld[cur] * 10 + kc;
               if (v > lim) xErr = 1;
               else begin fld[cur] = v; cnt[cur]++; end
            end
         end else if (kv && kc == 11) begin
            fld[cur] = 0; cnt[cur] = 0;
         end else if (kv && kc == 10) begin
            if (cnt[cur] == 0) xErr = 1;
            else if (cur == P_ACC) cur = P_PIN;
            else if (cur == P_PIN) begin menu = 0; cur = P_REQ; end
            else if (cur == P_OPT) begin
               if (fld[P_OPT] == 3) begin menu = 3; cur = P_REQ; end
               else if (fld[P_OPT] >= 4 && fld[P_OPT] <= 6) begin
                  menu = fld[P_OPT]; cur = P_AMT;
               end else xErr = 1;
            end
            else if (cur == P_AMT) cur = (menu == 6) ? P_DST : P_REQ;
            else cur = P_REQ;
         end
      end else if (cur == P_REQ) begin
         if (kv && kc == 12) pend = 1;
         if (reqReady) begin cur = P_WAIT; waited = 0; end
      end else begin
         if (respValid || (waited + 1 == TIMEOUT_CYCLES)) begin
            bad = !respValid || respError;
            if (menu == 0) begin
               if (bad) begin xErr = 1; clearAll(); cur = P_ACC; end
               else cur = P_OPT;
            end else begin
               cur = P_OPT;
               if (bad) xErr = 1;
               else begin
                  disp = int'(respBalance); xDv = 1;
                  fld[P_AMT] = 0; cnt[P_AMT] = 0;
                  fld[P_DST] = 0; cnt[P_DST] = 0;
               end
            end
            if (pend) begin
               xExit = 1; clearAll(); pend = 0; cur = P_ACC;
            end else if (kv && kc == 12) pend = 1;
         end else begin
            waited++;
            if (kv && kc == 12) pend = 1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("model.accNumber", int'(accNumber), fld[P_ACC]);
      checkOutput("model.pin", int'(pin), fld[P_PIN]);
      checkOutput("model.menuOption", int'(menuOption), menu);
      checkOutput("model.amount", int'(amount), fld[P_AMT]);
      checkOutput("model.destinationAcc", int'(destinationAcc), fld[P_DST]);
      checkOutput("model.reqValid", int'(reqValid), int'(cur == P_REQ));
      checkOutput("model.busy", int'(busy), int'(cur >= P_REQ));
      checkOutput("model.exit", int'(exit), int'(xExit));
      checkOutput("model.dispValid", int'(dispValid), int'(xDv));
      checkOutput("model.entryError", int'(entryError), int'(xErr));
      checkOutput("model.dispBalance", int'(dispBalance), disp);
   endtask

   // Model advances on every rising edge with the inputs the bench held
   // stable across it, then the DUT outputs are compared just after.
   always @(posedge clk) begin
      if (!rst_n) modelReset();
      else        modelStep();
      #1;
      compareAll();
   end

   // One cycle of stimulus: drive at the falling edge, return at the next
   // falling edge with the effect of the rising edge visible.
   task automatic applyStimulus(input logic kv, input logic [3:0] kc, input logic rr,
                                input logic rv, input logic re, input logic [10:0] rb);
      keyValid    = kv;
      keyCode     = kc;
      reqReady    = rr;
      respValid   = rv;
      respError   = re;
      respBalance = rb;
      @(negedge clk);
      keyValid  = 1'b0;
      respValid = 1'b0;
   endtask

   task automatic pressKey(input logic [3:0] kc);
      applyStimulus(1'b1, kc, readyDefault, 1'b0, 1'b0, 11'd0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'd0, readyDefault, 1'b0, 1'b0, 11'd0);
   endtask

   task automatic respond(input logic err, input logic [10:0] bal);
      applyStimulus(1'b0, 4'd0, readyDefault, 1'b1, err, bal);
   endtask

   initial begin
      rst_n = 1'b0; keyValid = 1'b0; keyCode = 4'd0; reqReady = 1'b0;
      respValid = 1'b0; respError = 1'b0; respBalance = 11'd0;
      readyDefault = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset.reqValid", int'(reqValid), 0);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.accNumber", int'(accNumber), 0);
      checkOutput("reset.dispBalance", int'(dispBalance), 0);
      checkOutput("reset.exit", int'(exit), 0);
      rst_n = 1'b1;
      idle();

      // Login 2175 / PIN 1, accepted immediately
      pressKey(4'd2); pressKey(4'd1); pressKey(4'd7); pressKey(4'd5);
      pressKey(K_ENT); pressKey(4'd1); pressKey(K_ENT);
      checkOutput("login.reqValid", int'(reqValid), 1);
      checkOutput("login.accNumber", int'(accNumber), 2175);
      checkOutput("login.pin", int'(pin), 1);
      checkOutput("login.menuOption", int'(menuOption), 0);
      idle();
      checkOutput("login.reqValidDrop", int'(reqValid), 0);
      checkOutput("login.busyWait", int'(busy), 1);
      respond(1'b0, 11'd0);
      checkOutput("login.entryError", int'(entryError), 0);
      checkOutput("login.busyDone", int'(busy), 0);

      // Withdraw 100, balance 400 returned
      pressKey(4'd4); pressKey(K_ENT);
      pressKey(4'd1); pressKey(4'd0); pressKey(4'd0); pressKey(K_ENT);
      checkOutput("withdraw.reqValid", int'(reqValid), 1);
      checkOutput("withdraw.menuOption", int'(menuOption), 4);
      checkOutput("withdraw.amount", int'(amount), 100);
      idle();
      respond(1'b0, 11'd400);
      checkOutput("withdraw.dispBalance", int'(dispBalance), 400);
      checkOutput("withdraw.dispValid", int'(dispValid), 1);
      checkOutput("withdraw.amountCleared", int'(amount), 0);
      idle();
      checkOutput("withdraw.dispValidPulse", int'(dispValid), 0);

      // Amount overflow, then cancel, then account overflow
      pressKey(4'd5); pressKey(K_ENT);
      pressKey(4'd2); pressKey(4'd0); pressKey(4'd4);
      checkOutput("amtOvf.amount", int'(amount), 204);
      pressKey(4'd8);
      checkOutput("amtOvf.entryError", int'(entryError), 1);
      checkOutput("amtOvf.amountKept", int'(amount), 204);
      pressKey(K_CAN);
      checkOutput("cancel.exit", int'(exit), 1);
      checkOutput("cancel.dispBalance", int'(dispBalance), 0);
      checkOutput("cancel.amount", int'(amount), 0);
      pressKey(4'd4); pressKey(4'd0); pressKey(4'd9);
      checkOutput("accOvf.accNumber", int'(accNumber), 409);
      pressKey(4'd6);
      checkOutput("accOvf.entryError", int'(entryError), 1);
      checkOutput("accOvf.accKept", int'(accNumber), 409);

      // Handshake stall with a cancel during the stall
      readyDefault = 1'b0;
      pressKey(K_ENT); pressKey(4'd1); pressKey(K_ENT);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i == 2, K_CAN, 1'b0, 1'b0, 1'b0, 11'd0);
         checkOutput("stall.reqValid", int'(reqValid), 1);
         checkOutput("stall.accNumber", int'(accNumber), 409);
         checkOutput("stall.exit", int'(exit), 0);
      end
      readyDefault = 1'b1;
      idle();
      checkOutput("stall.reqValidDrop", int'(reqValid), 0);
      respond(1'b0, 11'd0);
      checkOutput("stall.exit", int'(exit), 1);
      checkOutput("stall.accCleared", int'(accNumber), 0);
      checkOutput("stall.busy", int'(busy), 0);
      idle();
      checkOutput("stall.exitPulse", int'(exit), 0);
      pressKey(4'd5);
      checkOutput("stall.backInAcc", int'(accNumber), 5);

      // Balance request that times out
      pressKey(K_ENT); pressKey(4'd3); pressKey(K_ENT);
      idle();
      respond(1'b0, 11'd0);
      pressKey(4'd3); pressKey(K_ENT);
      checkOutput("timeout.menuOption", int'(menuOption), 3);
      idle();
      for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
         idle();
         checkOutput("timeout.entryError", int'(entryError), (k == TIMEOUT_CYCLES) ? 1 : 0);
         checkOutput("timeout.busy", int'(busy), (k == TIMEOUT_CYCLES) ? 0 : 1);
      end

      // Invalid option, then empty ENTER in the amount field
      pressKey(4'd7); pressKey(K_ENT);
      checkOutput("badOpt.entryError", int'(entryError), 1);
      checkOutput("badOpt.busy", int'(busy), 0);
      pressKey(4'd4); pressKey(K_ENT);
      pressKey(K_ENT);
      checkOutput("emptyAmt.entryError", int'(entryError), 1);

      // Response and cancel key in the same cycle
      pressKey(4'd1); pressKey(4'd0); pressKey(K_ENT);
      checkOutput("sameCyc.amount", int'(amount), 10);
      idle();
      applyStimulus(1'b1, K_CAN, 1'b1, 1'b1, 1'b0, 11'd77);
      checkOutput("sameCyc.dispValid", int'(dispValid), 1);
      checkOutput("sameCyc.dispBalance", int'(dispBalance), 77);
      checkOutput("sameCyc.exitNotYet", int'(exit), 0);
      idle();
      checkOutput("sameCyc.exit", int'(exit), 1);
      checkOutput("sameCyc.accNumber", int'(accNumber), 0);

      // Reset while a request is being offered
      readyDefault = 1'b0;
      pressKey(4'd3); pressKey(K_ENT); pressKey(4'd2); pressKey(K_ENT);
      checkOutput("midReset.reqBefore", int'(reqValid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midReset.reqValid", int'(reqValid), 0);
      checkOutput("midReset.busy", int'(busy), 0);
      checkOutput("midReset.accNumber", int'(accNumber), 0);
      checkOutput("midReset.exit", int'(exit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      readyDefault = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic kv, rr, rv, re;
         logic [3:0] kc;
         int r;
         if ($urandom_range(399) == 0) begin
            rst_n = 1'b0;
            idle();
            rst_n = 1'b1;
         end else begin
            kv = ($urandom_range(99) < 75);
            r  = $urandom_range(99);
            if (r < 60)      kc = 4'($urandom_range(9));
            else if (r < 85) kc = K_ENT;
            else if (r < 92) kc = K_CLR;
            else if (r < 95) kc = K_CAN;
            else             kc = 4'(13 + $urandom_range(2));
            rr = ($urandom_range(2) != 0);
            rv = ($urandom_range(5) == 0);
            re = ($urandom_range(3) == 0);
            applyStimulus(kv, kc, rr, rv, re, 11'($urandom_range(2047)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/atm_keypad_initiator.md
# atm_keypad_initiator

Customer-side front end of the ATM: turns a stream of keypad strobes into complete, stable ATM requests (login, balance, withdraw, withdraw-and-show, transfer). It issues each request over a valid/ready handshake, then waits for the controller's response. It sits between the keypad scanner and the ATM controller core, whose inputs are `accNumber`, `pin`, `menuOption`, `amount`, `destinationAcc` and `exit`.

## Interface
- TIMEOUT_CYCLES, 1000: cycles in WAIT_RESP before the request is abandoned
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- keyValid  in  1  one-cycle key strobe
- keyCode  in  4  0-9 digit; 4'hA ENTER; 4'hB CLEAR; 4'hC CANCEL; 4'hD-4'hF ignored
- reqValid  out  1  request fields valid
- reqReady  in  1  controller accepts request
- accNumber  out  12  account number (decimal value 0-4095)
- pin  out  4  PIN digit
- menuOption  out  3  0 login, 3 balance, 4 withdraw, 5 withdraw+show, 6 transfer
- amount  out  11  amount 0-2047
- destinationAcc  out  12  transfer destination
- respValid  in  1  one-cycle response strobe
- respError  in  1  response error flag
- respBalance  in  11  balance returned
- exit  out  1  one-cycle session-end pulse
- dispBalance  out  11  last good balance
- dispValid  out  1  one-cycle pulse when dispBalance updates
- entryError  out  1  one-cycle pulse on a rejected key, failed login, error response or timeout
- busy  out  1  high in REQ and WAIT_RESP

## Operation
- States: ACC, PIN, OPT, AMT, DST, REQ, WAIT_RESP.
- Digit entry in ACC/AMT/DST:
  - Field updates to field*10+digit.
  - If the result would exceed 4095 (ACC/DST) or 2047 (AMT), the digit is rejected, the field is unchanged and entryError pulses.
  - A per-field digit counter tracks digits entered.
- PIN takes one digit.
  - Any further digit in PIN overwrites the previous one.
  - A digit >9 cannot occur (codes A-F are not digits).
- OPT takes one digit and registers it as the pending option.
- ENTER with digit counter 0 in the current field: entryError, stay.
- ENTER transitions:
  - ACC -> PIN.
  - PIN -> REQ with menuOption=0 (login).
  - OPT with option 3 -> REQ.
  - OPT with option 4/5/6 -> AMT.
  - OPT with any other option: entryError, stay in OPT.
  - AMT -> REQ for options 4/5; AMT -> DST for option 6.
  - DST -> REQ.
- CLEAR zeroes the current field and its digit counter; in OPT it clears the pending option.
- CANCEL in ACC/PIN/OPT/AMT/DST:
  - exit pulses.
  - All fields and dispBalance are zeroed.
  - State goes to ACC.
- REQ:
  - reqValid=1; all request outputs held constant until the cycle where reqValid&&reqReady.
  - Then reqValid=0 and state goes to WAIT_RESP.
- Keys in REQ/WAIT_RESP:
  - Digits, ENTER and CLEAR are dropped silently.
  - CANCEL sets cancelPending.
- Response (respValid in WAIT_RESP):
  - Login OK -> OPT.
  - Login error -> entryError, fields cleared, ACC.
  - Non-login OK -> dispBalance=respBalance, dispValid pulse, OPT; amount/destinationAcc cleared.
  - Non-login error -> entryError, OPT.
- Timeout: TIMEOUT_CYCLES cycles in WAIT_RESP without respValid -> entryError, then the same destination as an error response.
- cancelPending: acted on when the response or timeout is resolved. Exit pulses the cycle after resolution, fields clear, state goes to ACC, cancelPending clears.
- respValid outside WAIT_RESP is ignored.

## Timing
- Reset values:
  - All outputs 0 (reqValid, exit, dispValid, entryError, busy, all fields, dispBalance).
  - State ACC; cancelPending 0; timeout counter 0.
- Each key is processed on the edge where keyValid=1; the field update is visible the next cycle.
- reqValid rises the cycle after the completing ENTER. Minimum handshake when reqReady is held high: 1 cycle in REQ.
- The timeout counter starts at 0 on entry to WAIT_RESP. A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES-1 wins over the timeout.
- keyValid and respValid in the same WAIT_RESP cycle: the response is processed, and a CANCEL key sets cancelPending, so the exit follows one cycle later.
- exit, dispValid and entryError are single-cycle registered pulses.
- rst_n asserted mid-request: reqValid drops asynchronously and no exit pulse is issued.

## Test plan
- Login OK: keys 2,1,7,5,ENTER,1,ENTER, reqReady=1 -> reqValid one cycle with accNumber=2175, pin=1, menuOption=0. Then respValid, respError=0 -> state OPT, no entryError.
- Withdraw: after login, keys 4,ENTER,1,0,0,ENTER -> request menuOption=4, amount=100. Response with respBalance=400 -> dispBalance=400, dispValid pulse.
- Overflow: in ACC keys 4,0,9,6 -> field 409, entryError on the 6. In AMT keys 2,0,4,8 -> amount 204, entryError on the 8.
- Handshake stall: reqReady=0 for 5 cycles with a CANCEL key during the stall -> reqValid and fields stable all 5 cycles, no exit. The response then produces an exit pulse one cycle after it, and the state returns to ACC.
- Timeout: TIMEOUT_CYCLES=8, no respValid -> entryError exactly 8 cycles after entering WAIT_RESP, state OPT.
- Invalid option / empty ENTER: key 7,ENTER in OPT -> entryError, stays OPT. ENTER with no digits in AMT -> entryError. Reset mid-REQ -> all outputs 0 immediately.
